// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: shares one AXI4 master port between the IFU (reads only)
// and the LSU (reads and writes), one single-beat transaction at a time.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ifu_req_i/ifu_addr_i          IFU fetch request, held until ifu_gnt_o
//   ifu_gnt_o, ifu_rsp_valid_o    IFU grant pulse and response pulse
//   lsu_req_i/wen/addr/size/wdata/wstrb  LSU request payload, held until lsu_gnt_o
//   lsu_gnt_o, lsu_rsp_valid_o    LSU grant pulse and response pulse
//   rsp_rdata_o, rsp_err_o        response data/error, valid with a rsp pulse
//   io_master_ar*/r*/aw*/w*/b*    AXI4 master channels
module axi_mem_arbiter #(
  parameter logic [3:0] IFU_ID = 4'd0,
  parameter logic [3:0] LSU_ID = 4'd1,
  parameter bit         RR_EN  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ifu_req_i,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_gnt_o,
  output logic        ifu_rsp_valid_o,
  input  logic        lsu_req_i,
  input  logic        lsu_wen_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_wstrb_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        io_master_arvalid,
  input  logic        io_master_arready,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  input  logic        io_master_rvalid,
  output logic        io_master_rready,
  input  logic [1:0]  io_master_rresp,
  input  logic [31:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid,
  output logic        io_master_awvalid,
  input  logic        io_master_awready,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  output logic        io_master_wvalid,
  input  logic        io_master_wready,
  output logic [31:0] io_master_wdata,
  output logic [3:0]  io_master_wstrb,
  output logic        io_master_wlast,
  input  logic        io_master_bvalid,
  output logic        io_master_bready,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_e;

  state_e      state_q, state_d;
  logic        prio_lsu_q, prio_lsu_d;   // round-robin pointer: 1 = LSU wins a tie
  logic        owner_lsu_q, owner_lsu_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        ifu_gnt_q, ifu_gnt_d;
  logic        lsu_gnt_q, lsu_gnt_d;
  logic        ifu_rsp_q, ifu_rsp_d;
  logic        lsu_rsp_q, lsu_rsp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic pick_lsu;
  logic aw_fin;
  logic w_fin;

  // Arbitration, channel sequencing and response capture
  always_comb begin
    state_d     = state_q;
    prio_lsu_d  = prio_lsu_q;
    owner_lsu_d = owner_lsu_q;
    addr_d      = addr_q;
    id_d        = id_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    ifu_gnt_d   = 1'b0;
    lsu_gnt_d   = 1'b0;
    ifu_rsp_d   = 1'b0;
    lsu_rsp_d   = 1'b0;
    pick_lsu    = lsu_req_i & (~ifu_req_i | ~RR_EN | prio_lsu_q);
    // a channel is finished once it handshook earlier or handshakes now
    aw_fin      = aw_done_q | (awvalid_q & io_master_awready);
    w_fin       = w_done_q | (wvalid_q & io_master_wready);

    case (state_q)
      S_IDLE: begin
        if (ifu_req_i | lsu_req_i) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (pick_lsu) begin
            lsu_gnt_d   = 1'b1;
            owner_lsu_d = 1'b1;
            prio_lsu_d  = 1'b0;
            addr_d      = lsu_addr_i;
            id_d        = LSU_ID;
            size_d      = lsu_size_i;
            wdata_d     = lsu_wdata_i;
            wstrb_d     = lsu_wstrb_i;
            state_d     = lsu_wen_i ? S_AW_W : S_AR;
          end else begin
            ifu_gnt_d   = 1'b1;
            owner_lsu_d = 1'b0;
            prio_lsu_d  = 1'b1;
            addr_d      = ifu_addr_i;
            id_d        = IFU_ID;
            size_d      = 3'b010;
            state_d     = S_AR;
          end
        end
      end
      // arvalid rises the cycle after grant and holds until accepted
      S_AR: begin
        if (arvalid_q & io_master_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      S_R: begin
        if (io_master_rvalid & rready_q) begin
          rready_d  = 1'b0;
          rdata_d   = io_master_rdata;
          err_d     = (io_master_rresp != 2'b00) | (io_master_rid != id_q) | ~io_master_rlast;
          ifu_rsp_d = ~owner_lsu_q;
          lsu_rsp_d = owner_lsu_q;
          state_d   = S_IDLE;
        end
      end
      // AW and W run independently; each is sent exactly once
      S_AW_W: begin
        awvalid_d = ~aw_fin;
        wvalid_d  = ~w_fin;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin & w_fin) begin
          bready_d = 1'b1;
          state_d  = S_B;
        end
      end
      S_B: begin
        if (io_master_bvalid & bready_q) begin
          bready_d  = 1'b0;
          rdata_d   = 32'd0;
          err_d     = (io_master_bresp != 2'b00) | (io_master_bid != id_q);
          lsu_rsp_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      prio_lsu_q  <= 1'b0;
      owner_lsu_q <= 1'b0;
      addr_q      <= 32'd0;
      id_q        <= 4'd0;
      size_q      <= 3'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      ifu_gnt_q   <= 1'b0;
      lsu_gnt_q   <= 1'b0;
      ifu_rsp_q   <= 1'b0;
      lsu_rsp_q   <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_lsu_q  <= prio_lsu_d;
      owner_lsu_q <= owner_lsu_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      ifu_gnt_q   <= ifu_gnt_d;
      lsu_gnt_q   <= lsu_gnt_d;
      ifu_rsp_q   <= ifu_rsp_d;
      lsu_rsp_q   <= lsu_rsp_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign ifu_gnt_o         = ifu_gnt_q;
  assign lsu_gnt_o         = lsu_gnt_q;
  assign ifu_rsp_valid_o   = ifu_rsp_q;
  assign lsu_rsp_valid_o   = lsu_rsp_q;
  assign rsp_rdata_o       = rdata_q;
  assign rsp_err_o         = err_q;
  assign io_master_arvalid = arvalid_q;
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = id_q;
  assign io_master_arlen   = 8'd0;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = 2'b01;
  assign io_master_rready  = rready_q;
  assign io_master_awvalid = awvalid_q;
  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = id_q;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = size_q;
  assign io_master_awburst = 2'b01;
  assign io_master_wvalid  = wvalid_q;
  assign io_master_wdata   = wdata_q;
  assign io_master_wstrb   = wstrb_q;
  assign io_master_wlast   = wvalid_q;
  assign io_master_bready  = bready_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: the bench plays the AXI slave for the
// round-robin instance; a second instance (fixed LSU priority) talks to an
// always-ready auto-responder.
module tb_axi_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // main instance (round-robin)
  logic        ifu_req, ifu_gnt, ifu_rsp, lsu_req, lsu_wen, lsu_gnt, lsu_rsp, rsp_err;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, rsp_rdata;
  logic [2:0]  lsu_size;
  logic [3:0]  lsu_wstrb;
  logic        arvalid, arready, rvalid, rready, rlast, awvalid, awready;
  logic        wvalid, wready, wlast, bvalid, bready;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [3:0]  arid, rid, awid, wstrb, bid;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;

  // fixed-priority instance
  logic        ifu_req1, ifu_gnt1, ifu_rsp1, lsu_req1, lsu_gnt1, lsu_rsp1, rsp_err1;
  logic [31:0] rsp_rdata1, araddr1, awaddr1, wdata1;
  logic        arvalid1, rready1, awvalid1, wvalid1, wlast1, bready1;
  logic [3:0]  arid1, awid1, wstrb1;
  logic [7:0]  arlen1, awlen1;
  logic [2:0]  arsize1, awsize1;
  logic [1:0]  arburst1, awburst1;

  logic [31:0] mem [16];

  axi_mem_arbiter u_dut (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_gnt_o(ifu_gnt), .ifu_rsp_valid_o(ifu_rsp),
    .lsu_req_i(lsu_req), .lsu_wen_i(lsu_wen), .lsu_addr_i(lsu_addr), .lsu_size_i(lsu_size),
    .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb), .lsu_gnt_o(lsu_gnt), .lsu_rsp_valid_o(lsu_rsp),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rresp(rresp),
    .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp), .io_master_bid(bid)
  );

  axi_mem_arbiter #(.RR_EN(1'b0)) u_fixed (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_i(ifu_req1), .ifu_addr_i(32'h8000_0040), .ifu_gnt_o(ifu_gnt1), .ifu_rsp_valid_o(ifu_rsp1),
    .lsu_req_i(lsu_req1), .lsu_wen_i(1'b0), .lsu_addr_i(32'h8000_0080), .lsu_size_i(3'd2),
    .lsu_wdata_i(32'd0), .lsu_wstrb_i(4'd0), .lsu_gnt_o(lsu_gnt1), .lsu_rsp_valid_o(lsu_rsp1),
    .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err1),
    .io_master_arvalid(arvalid1), .io_master_arready(1'b1), .io_master_araddr(araddr1),
    .io_master_arid(arid1), .io_master_arlen(arlen1), .io_master_arsize(arsize1), .io_master_arburst(arburst1),
    .io_master_rvalid(rready1), .io_master_rready(rready1), .io_master_rresp(2'b00),
    .io_master_rdata(32'h1234_5678), .io_master_rlast(1'b1), .io_master_rid(arid1),
    .io_master_awvalid(awvalid1), .io_master_awready(1'b1), .io_master_awaddr(awaddr1),
    .io_master_awid(awid1), .io_master_awlen(awlen1), .io_master_awsize(awsize1), .io_master_awburst(awburst1),
    .io_master_wvalid(wvalid1), .io_master_wready(1'b1), .io_master_wdata(wdata1),
    .io_master_wstrb(wstrb1), .io_master_wlast(wlast1),
    .io_master_bvalid(bready1), .io_master_bready(bready1), .io_master_bresp(2'b00), .io_master_bid(awid1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Full read through the main instance; bench acts as the AXI slave.
  task automatic do_read(input logic [1:0] req_mask, input logic exp_lsu, input logic [31:0] addr,
                         input logic [2:0] size, input int ar_dly, input int r_dly,
                         input logic [31:0] data, input logic [1:0] resp, input logic [3:0] rid_v,
                         input logic last, input logic exp_err, input string name);
    logic [1:0] exp_pair;
    logic [2:0] exp_size;
    logic [3:0] exp_id;
    exp_pair = exp_lsu ? 2'b01 : 2'b10;
    exp_size = exp_lsu ? size : 3'b010;
    exp_id   = exp_lsu ? 4'd1 : 4'd0;
    ifu_req = req_mask[0]; ifu_addr = addr;
    lsu_req = req_mask[1]; lsu_wen = 1'b0; lsu_addr = addr; lsu_size = size;
    step();
    checks++;
    if ({ifu_gnt, lsu_gnt} !== exp_pair) begin
      failures++; $display("FAIL %s grant {ifu,lsu}: got %b want %b", name, {ifu_gnt, lsu_gnt}, exp_pair);
    end
    ifu_req = 1'b0; lsu_req = 1'b0;
    step();
    checks++;
    if ({arvalid, ifu_gnt, lsu_gnt} !== 3'b100 || araddr !== addr || arid !== exp_id ||
        arsize !== exp_size || arlen !== 8'd0 || arburst !== 2'b01) begin
      failures++;
      $display("FAIL %s ar: got v=%b gnt=%b%b addr=%h id=%h size=%h len=%h burst=%b want v=1 addr=%h id=%h size=%h",
               name, arvalid, ifu_gnt, lsu_gnt, araddr, arid, arsize, arlen, arburst, addr, exp_id, exp_size);
    end
    for (int i = 0; i < ar_dly; i++) begin
      step();
      checks++;
      if (arvalid !== 1'b1 || araddr !== addr || arid !== exp_id) begin
        failures++; $display("FAIL %s ar_stall: got v=%b addr=%h id=%h want v=1 addr=%h id=%h",
                             name, arvalid, araddr, arid, addr, exp_id);
      end
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    checks++;
    if ({arvalid, rready} !== 2'b01) begin
      failures++; $display("FAIL %s r_phase {arvalid,rready}: got %b want 01", name, {arvalid, rready});
    end
    for (int i = 0; i < r_dly; i++) step();
    rvalid = 1'b1; rdata = data; rresp = resp; rid = rid_v; rlast = last;
    step();
    rvalid = 1'b0;
    checks++;
    if ({ifu_rsp, lsu_rsp} !== exp_pair || rsp_rdata !== data || rsp_err !== exp_err || rready !== 1'b0) begin
      failures++;
      $display("FAIL %s rsp: got rsp=%b data=%h err=%b rready=%b want rsp=%b data=%h err=%b rready=0",
               name, {ifu_rsp, lsu_rsp}, rsp_rdata, rsp_err, rready, exp_pair, data, exp_err);
    end
    step();
    checks++;
    if ({ifu_rsp, lsu_rsp} !== 2'b00) begin
      failures++; $display("FAIL %s rsp_pulse_width: got %b want 00", name, {ifu_rsp, lsu_rsp});
    end
  endtask

  // Full LSU write; aw/w ready each asserted for exactly one cycle at its delay.
  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input logic [1:0] bresp_v, input logic [3:0] bid_v, input logic exp_err,
                          input string name);
    int n;
    lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = addr; lsu_size = size; lsu_wdata = wd; lsu_wstrb = strb;
    step();
    checks++;
    if ({ifu_gnt, lsu_gnt} !== 2'b01) begin
      failures++; $display("FAIL %s grant {ifu,lsu}: got %b want 01", name, {ifu_gnt, lsu_gnt});
    end
    lsu_req = 1'b0; lsu_wen = 1'b0;
    step();
    checks++;
    if ({awvalid, wvalid, wlast, arvalid} !== 4'b1110 || awaddr !== addr || awid !== 4'd1 ||
        awsize !== size || wdata !== wd || wstrb !== strb || awlen !== 8'd0 || awburst !== 2'b01) begin
      failures++;
      $display("FAIL %s aw_w: got aw=%b w=%b last=%b ar=%b addr=%h id=%h size=%h data=%h strb=%h want 1110 addr=%h data=%h strb=%h",
               name, awvalid, wvalid, wlast, arvalid, awaddr, awid, awsize, wdata, wstrb, addr, wd, strb);
    end
    n = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int c = 0; c <= n; c++) begin
      awready = (c == aw_dly);
      wready  = (c == w_dly);
      step();
      checks++;
      if ({awvalid, wvalid, wlast} !== {c < aw_dly, c < w_dly, c < w_dly} || awaddr !== addr || wdata !== wd) begin
        failures++;
        $display("FAIL %s aw_w_cycle%0d: got aw=%b w=%b last=%b addr=%h data=%h want aw=%b w=%b addr=%h data=%h",
                 name, c, awvalid, wvalid, wlast, awaddr, wdata, c < aw_dly, c < w_dly, addr, wd);
      end
    end
    awready = 1'b0; wready = 1'b0;
    checks++;
    if (bready !== 1'b1) begin
      failures++; $display("FAIL %s bready: got %b want 1", name, bready);
    end
    bvalid = 1'b1; bresp = bresp_v; bid = bid_v;
    step();
    bvalid = 1'b0;
    checks++;
    if ({ifu_rsp, lsu_rsp} !== 2'b01 || rsp_rdata !== 32'd0 || rsp_err !== exp_err || bready !== 1'b0) begin
      failures++;
      $display("FAIL %s b_rsp: got rsp=%b data=%h err=%b bready=%b want rsp=01 data=0 err=%b bready=0",
               name, {ifu_rsp, lsu_rsp}, rsp_rdata, rsp_err, bready, exp_err);
    end
    step();
    checks++;
    if ({ifu_rsp, lsu_rsp} !== 2'b00) begin
      failures++; $display("FAIL %s rsp_pulse_width: got %b want 00", name, {ifu_rsp, lsu_rsp});
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, ifu_gnt, lsu_gnt, ifu_rsp, lsu_rsp} !== 9'd0) begin
      failures++; $display("FAIL reset_ctrl: got %b want 000000000",
                           {arvalid, rready, awvalid, wvalid, bready, ifu_gnt, lsu_gnt, ifu_rsp, lsu_rsp});
    end
    checks++;
    if (araddr !== 32'd0 || arid !== 4'd0 || wdata !== 32'd0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      failures++; $display("FAIL reset_regs: got addr=%h id=%h wdata=%h rdata=%h err=%b want zeros",
                           araddr, arid, wdata, rsp_rdata, rsp_err);
    end
    checks++;
    if (arlen !== 8'd0 || awlen !== 8'd0 || arburst !== 2'b01 || awburst !== 2'b01 || wlast !== 1'b0) begin
      failures++; $display("FAIL reset_const: got arlen=%h awlen=%h arburst=%b awburst=%b wlast=%b",
                           arlen, awlen, arburst, awburst, wlast);
    end
  endtask

  task automatic test_ifu_read();
    do_read(2'b01, 1'b0, 32'h8000_0000, 3'd0, 2, 1, 32'h0000_0413, 2'b00, 4'd0, 1'b1, 1'b0, "ifu_read");
  endtask

  task automatic test_lsu_write();
    do_write(32'h8000_0100, 3'd2, 32'hDEAD_BEEF, 4'hF, 3, 0, 2'b00, 4'd1, 1'b0, "lsu_write_w_first");
    do_write(32'h8000_0104, 3'd1, 32'h0000_BEEF, 4'h3, 0, 2, 2'b00, 4'd1, 1'b0, "lsu_write_aw_first");
    do_write(32'h8000_0108, 3'd0, 32'h00AB_0000, 4'h4, 1, 1, 2'b00, 4'd1, 1'b0, "lsu_write_same");
  endtask

  task automatic test_errors();
    do_read(2'b10, 1'b1, 32'h8000_0200, 3'd0, 0, 0, 32'h0000_00AA, 2'b10, 4'd1, 1'b1, 1'b1, "err_rresp");
    do_read(2'b10, 1'b1, 32'h8000_0204, 3'd2, 0, 0, 32'h1111_2222, 2'b00, 4'd1, 1'b0, 1'b1, "err_rlast");
    do_read(2'b01, 1'b0, 32'h8000_0208, 3'd2, 1, 0, 32'h3333_4444, 2'b00, 4'd3, 1'b1, 1'b1, "err_rid");
    do_write(32'h8000_0210, 3'd2, 32'h5555_6666, 4'hF, 0, 0, 2'b00, 4'd5, 1'b1, "err_bid");
    do_write(32'h8000_0214, 3'd2, 32'h7777_8888, 4'hF, 0, 0, 2'b11, 4'd1, 1'b1, "err_bresp");
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 4; i++)
      do_read(2'b11, 1'(i % 2), 32'h8000_0300, 3'd2, 0, 0, 32'hC0DE_0000 + 32'(i), 2'b00,
              (i % 2 == 1) ? 4'd1 : 4'd0, 1'b1, 1'b0, "round_robin");
  endtask

  task automatic test_fixed_priority();
    int n;
    for (int i = 0; i < 4; i++) begin
      ifu_req1 = 1'b1; lsu_req1 = 1'b1;
      step();
      checks++;
      if ({ifu_gnt1, lsu_gnt1} !== 2'b01) begin
        failures++; $display("FAIL fixed_prio_%0d grant {ifu,lsu}: got %b want 01", i, {ifu_gnt1, lsu_gnt1});
      end
      ifu_req1 = 1'b0; lsu_req1 = 1'b0;
      n = 0;
      while (lsu_rsp1 !== 1'b1 && n < 10) begin
        step();
        n++;
      end
      checks++;
      if (lsu_rsp1 !== 1'b1 || ifu_rsp1 !== 1'b0 || rsp_rdata1 !== 32'h1234_5678) begin
        failures++; $display("FAIL fixed_prio_%0d rsp: got lsu=%b ifu=%b data=%h want 1 0 12345678",
                             i, lsu_rsp1, ifu_rsp1, rsp_rdata1);
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    ifu_req = 1'b1; ifu_addr = 32'h8000_0400;
    step();
    ifu_req = 1'b0;
    step();
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = 2'b00; rid = 4'd0; rlast = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, ifu_rsp, lsu_rsp} !== 7'd0) begin
      failures++; $display("FAIL mid_reset_drop: got %b want 0000000",
                           {arvalid, rready, awvalid, wvalid, bready, ifu_rsp, lsu_rsp});
    end
    rst = 1'b0;
    step();
    rvalid = 1'b0;
    checks++;
    if ({ifu_rsp, lsu_rsp, rready} !== 3'b000) begin
      failures++; $display("FAIL mid_reset_no_rsp: got %b want 000", {ifu_rsp, lsu_rsp, rready});
    end
    // idle again: a new request is granted on the very next edge
    do_read(2'b01, 1'b0, 32'h8000_0404, 3'd2, 0, 0, 32'h0000_0513, 2'b00, 4'd0, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    logic        lsu, wr;
    int          idx;
    logic [31:0] wd;
    logic [3:0]  strb;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0101_0101 * 32'(i);
    for (int t = 0; t < 40; t++) begin
      lsu = 1'($urandom_range(1, 0));
      wr  = lsu & 1'($urandom_range(1, 0));
      idx = int'($urandom_range(15, 0));
      if (wr) begin
        wd   = $urandom;
        strb = 4'($urandom_range(15, 1));
        do_write(32'h8000_1000 + 32'(idx * 4), 3'd2, wd, strb, int'($urandom_range(3, 0)),
                 int'($urandom_range(3, 0)), 2'b00, 4'd1, 1'b0, "rand_write");
        for (int b = 0; b < 4; b++)
          if (strb[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        do_read(lsu ? 2'b10 : 2'b01, lsu, 32'h8000_1000 + 32'(idx * 4), 3'd2, int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), mem[idx], 2'b00, lsu ? 4'd1 : 4'd0, 1'b1, 1'b0, "rand_read");
      end
    end
  endtask

  initial begin
    ifu_req = 1'b0; ifu_addr = 32'd0; lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'd0;
    lsu_size = 3'd0; lsu_wdata = 32'd0; lsu_wstrb = 4'd0;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 32'd0; rlast = 1'b0; rid = 4'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
    ifu_req1 = 1'b0; lsu_req1 = 1'b0;
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_errors();
    test_round_robin();
    test_fixed_priority();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion want finish before 500us");
    $fatal(1, "timeout");
  end

endmodule
